// File: rtl/boot_loader.sv
// boot_loader: streams program words from a valid/ready source into
// instruction memory, holds the CPU in reset while loading, releases it
// after a short hold, then ends the run after a cycle budget.
// Optional build macro: BOOT_LOADER_CHECKSUM_EN adds a running sum of
// all accepted words on o_checksum (tied to zero when undefined).
module boot_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 256,
    parameter int RESET_HOLD     = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_load_valid,
    input  logic [DATA_WIDTH-1:0]        i_load_data,
    input  logic                         i_load_last,
    output logic                         o_load_ready,
    output logic                         o_mem_we,
    output logic [$clog2(MEM_DEPTH)+1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    output logic                         o_cpu_reset_n,
    output logic                         o_running,
    output logic                         o_done,
    output logic                         o_error,
    output logic [$clog2(MEM_DEPTH):0]   o_word_count,
    output logic [DATA_WIDTH-1:0]        o_checksum
);

    localparam int AW = $clog2(MEM_DEPTH);

    // A hold time of zero still keeps the CPU in reset for one cycle.
    localparam int HOLD_CYC = (RESET_HOLD > 0) ? RESET_HOLD : 1;
    localparam int HW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    // The run counter must be able to hold TIMEOUT_CYCLES itself, since it
    // saturates there once the run has ended.
    localparam int RW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [RW-1:0] RUN_LAST = (TIMEOUT_CYCLES > 0) ? RW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        LOAD,
        HOLD,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [AW:0]           count_q, count_d;
    logic                  memWe_q, memWe_d;
    logic [AW+1:0]         memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [RW-1:0]         run_q, run_d;
    logic                  beat;

    assign beat = i_load_valid && (state_q == LOAD);

    // State register plus the registered write port and counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= LOAD;
            count_q    <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            hold_q     <= '0;
            run_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            hold_q     <= hold_d;
            run_q      <= run_d;
        end
    end

    // Next-state logic: accept beats in LOAD, time the reset hold, then
    // count run cycles until the budget is spent.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        hold_d     = hold_q;
        run_d      = run_q;
        case (state_q)
            LOAD: begin
                hold_d = '0;
                run_d  = '0;
                if (beat) begin
                    memWe_d    = 1'b1;
                    memAddr_d  = {count_q[AW-1:0], 2'b00};
                    memWdata_d = i_load_data;
                    count_d    = count_q + 1'b1;
                    if (i_load_last) begin
                        state_d = HOLD;
                    end else if (count_q == LAST_IDX) begin
                        state_d = ERR;
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (TIMEOUT_CYCLES != 0) begin
                    run_d = run_q + 1'b1;
                    if (run_q == RUN_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign o_load_ready  = (state_q == LOAD);
    assign o_mem_we      = memWe_q;
    assign o_mem_addr    = memAddr_q;
    assign o_mem_wdata   = memWdata_q;
    assign o_cpu_reset_n = (state_q == RUN);
    assign o_running     = (state_q == RUN);
    assign o_done        = (state_q == DONE);
    assign o_error       = (state_q == ERR);
    assign o_word_count  = count_q;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    // Running sum of accepted words, visible alongside the memory write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            checksum_q <= '0;
        end else if (beat) begin
            checksum_q <= checksum_q + i_load_data;
        end
    end

    assign o_checksum = checksum_q;
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed checks of boot_loader. Two instances share the
// same stimulus: dutA (deep memory, 10-cycle budget) and dutB (4-word
// memory) for the overflow and full-memory cases.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        last = 1'b0;

    logic        aReady, aWe, aRstN, aRun, aDone, aErr;
    logic [9:0]  aAddr;
    logic [31:0] aWdata, aSum;
    logic [8:0]  aCount;

    logic        bReady, bWe, bRstN, bRun, bDone, bErr;
    logic [3:0]  bAddr;
    logic [31:0] bWdata, bSum;
    logic [2:0]  bCount;

    int checks = 0;
    int errors = 0;

    boot_loader #(.DATA_WIDTH(32), .MEM_DEPTH(256), .RESET_HOLD(3), .TIMEOUT_CYCLES(10)) dutA (
        .i_clk(clk), .i_reset(rst), .i_load_valid(valid), .i_load_data(data),
        .i_load_last(last), .o_load_ready(aReady), .o_mem_we(aWe), .o_mem_addr(aAddr),
        .o_mem_wdata(aWdata), .o_cpu_reset_n(aRstN), .o_running(aRun), .o_done(aDone),
        .o_error(aErr), .o_word_count(aCount), .o_checksum(aSum)
    );

    boot_loader #(.DATA_WIDTH(32), .MEM_DEPTH(4), .RESET_HOLD(3), .TIMEOUT_CYCLES(10)) dutB (
        .i_clk(clk), .i_reset(rst), .i_load_valid(valid), .i_load_data(data),
        .i_load_last(last), .o_load_ready(bReady), .o_mem_we(bWe), .o_mem_addr(bAddr),
        .o_mem_wdata(bWdata), .o_cpu_reset_n(bRstN), .o_running(bRun), .o_done(bDone),
        .o_error(bErr), .o_word_count(bCount), .o_checksum(bSum)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it, so inputs changed
    // here are sampled on the following edge and outputs reflect this edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b1;
        valid = 1'b0;
        last = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Reset values on both instances, with valid asserted during reset.
    task automatic test_reset;
        rst = 1'b1;
        valid = 1'b1;
        data = 32'hDEADBEEF;
        tick();
        rst = 1'b0;
        valid = 1'b0;
        checks++;
        if ({aReady, aWe, aRstN, aRun, aDone, aErr} !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL reset_flags_a: got %b expected 100000", {aReady, aWe, aRstN, aRun, aDone, aErr});
        end
        checks++;
        if (aAddr !== 10'd0 || aWdata !== 32'd0 || aCount !== 9'd0 || aSum !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_values_a: addr=%0h wdata=%0h count=%0d sum=%0h expected all 0", aAddr, aWdata, aCount, aSum);
        end
        checks++;
        if ({bReady, bWe, bRstN, bRun, bDone, bErr} !== 6'b100000 || bCount !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_b: flags=%b count=%0d expected 100000 count 0", {bReady, bWe, bRstN, bRun, bDone, bErr}, bCount);
        end
    endtask

    // Five-word program, then the CPU reset hold of three cycles.
    task automatic test_load5;
        logic [31:0] prog [5];
        prog[0] = 32'h001000B3; prog[1] = 32'h00308233; prog[2] = 32'h401282B3;
        prog[3] = 32'h0083E333; prog[4] = 32'h00227233;
        doReset();
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data = prog[i];
            last = (i == 4);
            tick();
            checks++;
            if (aWe !== 1'b1 || aAddr !== 10'(4 * i) || aWdata !== prog[i] || aCount !== 9'(i + 1)) begin
                errors++;
                $display("[TB] FAIL load5_write%0d: we=%b addr=%0d data=%h count=%0d expected we=1 addr=%0d data=%h count=%0d",
                         i, aWe, aAddr, aWdata, aCount, 4 * i, prog[i], i + 1);
            end
        end
        valid = 1'b0;
        last = 1'b0;
        checks++;
        if (aRstN !== 1'b0 || aReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load5_hold_entry: rstn=%b ready=%b expected 0 0", aRstN, aReady);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (aRstN !== (k == 3) || aRun !== (k == 3) || aWe !== 1'b0) begin
                errors++;
                $display("[TB] FAIL load5_hold%0d: rstn=%b run=%b we=%b expected rstn=%b run=%b we=0",
                         k, aRstN, aRun, aWe, (k == 3), (k == 3));
            end
        end
    endtask

    // Valid toggles every other cycle: one write per handshake, contiguous.
    task automatic test_valid_toggle;
        int k = 0;
        doReset();
        for (int i = 0; i < 8; i++) begin
            valid = (i % 2 == 0);
            data = 32'h100 + i;
            last = (i == 6);
            if (i <= 6) begin
                checks++;
                if (aReady !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL toggle_ready%0d: got %b expected 1", i, aReady);
                end
            end
            tick();
            checks++;
            if (i % 2 == 0) begin
                if (aWe !== 1'b1 || aAddr !== 10'(4 * k) || aWdata !== 32'h100 + i) begin
                    errors++;
                    $display("[TB] FAIL toggle_write%0d: we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                             i, aWe, aAddr, aWdata, 4 * k, 32'h100 + i);
                end
                k++;
            end else if (aWe !== 1'b0) begin
                errors++;
                $display("[TB] FAIL toggle_idle%0d: we=%b expected 0", i, aWe);
            end
        end
        valid = 1'b0;
        last = 1'b0;
        checks++;
        if (aCount !== 9'd4) begin
            errors++;
            $display("[TB] FAIL toggle_count: got %0d expected 4", aCount);
        end
    endtask

    // Four-word memory overflows on the fourth beat without last.
    task automatic test_overflow;
        doReset();
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            data = 32'hA0 + i;
            last = 1'b0;
            tick();
            checks++;
            if (bWe !== 1'b1 || bAddr !== 4'(4 * i) || bWdata !== 32'hA0 + i || bErr !== (i == 3) || bReady !== (i != 3)) begin
                errors++;
                $display("[TB] FAIL overflow_beat%0d: we=%b addr=%0d data=%h err=%b ready=%b expected we=1 addr=%0d data=%h err=%b ready=%b",
                         i, bWe, bAddr, bWdata, bErr, bReady, 4 * i, 32'hA0 + i, (i == 3), (i != 3));
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        valid = 1'b0;
        checks++;
        if (bErr !== 1'b1 || bRstN !== 1'b0 || bReady !== 1'b0 || bWe !== 1'b0 || bCount !== 3'd4) begin
            errors++;
            $display("[TB] FAIL overflow_sticky: err=%b rstn=%b ready=%b we=%b count=%0d expected 1 0 0 0 4",
                     bErr, bRstN, bReady, bWe, bCount);
        end
    endtask

    // Last on the final memory slot is legal and leads to HOLD then RUN.
    task automatic test_full_last;
        int n = 0;
        doReset();
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            data = 32'hB0 + i;
            last = (i == 3);
            tick();
        end
        valid = 1'b0;
        last = 1'b0;
        checks++;
        if (bErr !== 1'b0 || bAddr !== 4'd12 || bWe !== 1'b1 || bCount !== 3'd4 || bReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_last: err=%b addr=%0d we=%b count=%0d ready=%b expected 0 12 1 4 0",
                     bErr, bAddr, bWe, bCount, bReady);
        end
        while (!bRun && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("[TB] FAIL full_last_release: cycles=%0d expected 3", n);
        end
    endtask

    // One-word program with a 10-cycle budget, then sticky DONE.
    task automatic test_timeout;
        int n = 0;
        int runCycles = 0;
        doReset();
        valid = 1'b1;
        data = 32'h00000013;
        last = 1'b1;
        tick();
        valid = 1'b0;
        last = 1'b0;
        checks++;
        if (aCount !== 9'd1 || aWe !== 1'b1 || aAddr !== 10'd0) begin
            errors++;
            $display("[TB] FAIL timeout_load: count=%0d we=%b addr=%0d expected 1 1 0", aCount, aWe, aAddr);
        end
        while (!aRun && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (aRun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_start: running=%b after %0d cycles expected 1", aRun, n);
        end
        while (aRun && runCycles < 50) begin
            runCycles++;
            tick();
        end
        checks++;
        if (runCycles !== 10) begin
            errors++;
            $display("[TB] FAIL timeout_run_len: got %0d expected 10", runCycles);
        end
        checks++;
        if (aDone !== 1'b1 || aRstN !== 1'b0 || aRun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_done: done=%b rstn=%b run=%b expected 1 0 0", aDone, aRstN, aRun);
        end
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        valid = 1'b0;
        checks++;
        if (aDone !== 1'b1 || aWe !== 1'b0 || aCount !== 9'd1 || aReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: done=%b we=%b count=%0d ready=%b expected 1 0 1 0", aDone, aWe, aCount, aReady);
        end
    endtask

    // Reset pulsed while running returns to LOAD; a reload then works.
    task automatic test_reset_in_run;
        int n = 0;
        doReset();
        valid = 1'b1;
        data = 32'h11;
        last = 1'b1;
        tick();
        valid = 1'b0;
        last = 1'b0;
        while (!aRun && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (aReady !== 1'b1 || aCount !== 9'd0 || aRstN !== 1'b0 || aRun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: ready=%b count=%0d rstn=%b run=%b expected 1 0 0 0", aReady, aCount, aRstN, aRun);
        end
        for (int i = 0; i < 2; i++) begin
            valid = 1'b1;
            data = 32'h500 + i;
            last = (i == 1);
            tick();
            checks++;
            if (aWe !== 1'b1 || aAddr !== 10'(4 * i) || aWdata !== 32'h500 + i || aCount !== 9'(i + 1)) begin
                errors++;
                $display("[TB] FAIL reload%0d: we=%b addr=%0d data=%h count=%0d expected 1 %0d %h %0d",
                         i, aWe, aAddr, aWdata, aCount, 4 * i, 32'h500 + i, i + 1);
            end
        end
        valid = 1'b0;
        last = 1'b0;
    endtask

    // Checksum wraps modulo 2^32, or stays zero when the feature is absent.
    task automatic test_checksum;
        logic [31:0] expFirst;
        logic [31:0] expSecond;
`ifdef BOOT_LOADER_CHECKSUM_EN
        expFirst = 32'hFFFFFFFF;
        expSecond = 32'h00000001;
`else
        expFirst = 32'h0;
        expSecond = 32'h0;
`endif
        doReset();
        valid = 1'b1;
        data = 32'hFFFFFFFF;
        last = 1'b0;
        tick();
        checks++;
        if (aSum !== expFirst) begin
            errors++;
            $display("[TB] FAIL checksum_first: got %h expected %h", aSum, expFirst);
        end
        data = 32'h00000002;
        last = 1'b1;
        tick();
        valid = 1'b0;
        last = 1'b0;
        checks++;
        if (aSum !== expSecond) begin
            errors++;
            $display("[TB] FAIL checksum_second: got %h expected %h", aSum, expSecond);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_load5();
        test_valid_toggle();
        test_overflow();
        test_full_last();
        test_timeout();
        test_reset_in_run();
        test_checksum();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
